cmac_tx_frame_buffer: RTL and testbench

CMAC_TX_FRAME_BUFFER -- requirements
Module: cmac_tx_frame_buffer

---
 rtl/zeus_eth_pkg.sv | 17 +
 rtl/sdp_ram.sv | 37 +++
 rtl/cmac_tx_frame_buffer.sv | 168 ++++++++++++++++
 tb/tb_cmac_tx_frame_buffer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeus_eth_pkg.sv
// rtl/zeus_eth_pkg.sv - shared ethernet constants and types
//
// Purpose: constants shared by the ethernet TX path (AXIS data width,
// largest accepted frame in beats) and the frame-buffer input state type.
package zeus_eth_pkg;

  localparam int ETH_AXIS_DATA_WIDTH = 512;
  // 1518 B / 64 B per beat, rounded up
  localparam int ETH_MAX_FRAME_BEATS = 24;

  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_WRITE = 2'd1,
    WR_DROP  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sdp_ram.sv
// rtl/sdp_ram.sv - simple dual-port RAM with 1-cycle registered read
//
// Purpose: one write port, one read port; read data is registered and only
// updates when re=1, so it holds its value while the reader is stalled.
// Ports:
//   clk          - clock
//   we/waddr/wdata - write port
//   re/raddr     - read request, data appears on rdata the next cycle
//   rdata        - registered read data
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cmac_tx_frame_buffer.sv
// rtl/cmac_tx_frame_buffer.sv - store-and-forward TX frame buffer in front of CMAC
//
// Purpose: buffers whole frames from ethernet_tx and only releases a frame
// once its last beat is stored; oversize frames are dropped and counted.
// Ports:
//   tx_axis_aclk / tx_axis_areset - clock, synchronous active-high reset
//   s_axis_*                      - frame input (tdata/tkeep/tvalid/tlast/tready)
//   cmac_tx_axis_*                - frame output to CMAC
//   frame_count                   - committed frames not yet fully sent
//   drop_count                    - oversize frames dropped (wraps)
module cmac_tx_frame_buffer
  import zeus_eth_pkg::*;
#(
  parameter int DATA_WIDTH      = ETH_AXIS_DATA_WIDTH,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int DEPTH           = 64,
  parameter int MAX_FRAME_BEATS = ETH_MAX_FRAME_BEATS
) (
  input  logic                     tx_axis_aclk,
  input  logic                     tx_axis_areset,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH-1:0]    cmac_tx_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    cmac_tx_axis_tkeep,
  output logic                     cmac_tx_axis_tvalid,
  output logic                     cmac_tx_axis_tlast,
  input  logic                     cmac_tx_axis_tready,
  output logic [$clog2(DEPTH):0]   frame_count,
  output logic [31:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int MW = DATA_WIDTH + KEEP_WIDTH + 1;

  wr_state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] beat_cnt_q, beat_cnt_d;
  logic [PW-1:0] frame_count_q, frame_count_d;
  logic [31:0]   drop_count_q, drop_count_d;
  logic          commit_q, commit_d;
  logic          out_valid_q, out_valid_d;

  logic [PW-1:0] occ;
  logic          space_ok;
  logic          in_fire;
  logic          ram_we;
  logic          ram_re;
  logic          out_hs;
  logic [MW-1:0] ram_rdata;

  // occupancy counts uncommitted beats too, so a frame in flight keeps its
  // reservation until it is committed or rolled back
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign space_ok = (PW'(DEPTH) - occ) >= PW'(MAX_FRAME_BEATS);

  assign s_axis_tready = !tx_axis_areset && ((state_q != WR_IDLE) || space_ok);
  assign in_fire       = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    beat_cnt_d   = beat_cnt_q;
    drop_count_d = drop_count_q;
    commit_d     = 1'b0;
    ram_we       = 1'b0;
    case (state_q)
      WR_IDLE, WR_WRITE: begin
        if (in_fire) begin
          if (beat_cnt_q == PW'(MAX_FRAME_BEATS)) begin
            // one beat too many: never stored; a last beat here ends the
            // drop immediately, otherwise sink the rest of the frame
            if (s_axis_tlast) begin
              wr_ptr_d     = wr_commit_q;
              drop_count_d = drop_count_q + 32'd1;
              beat_cnt_d   = '0;
              state_d      = WR_IDLE;
            end else begin
              state_d = WR_DROP;
            end
          end else begin
            ram_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + PW'(1);
            beat_cnt_d = beat_cnt_q + PW'(1);
            if (s_axis_tlast) begin
              wr_commit_d = wr_ptr_q + PW'(1);
              commit_d    = 1'b1;
              beat_cnt_d  = '0;
              state_d     = WR_IDLE;
            end else begin
              state_d = WR_WRITE;
            end
          end
        end
      end
      WR_DROP: begin
        if (in_fire && s_axis_tlast) begin
          wr_ptr_d     = wr_commit_q;
          drop_count_d = drop_count_q + 32'd1;
          beat_cnt_d   = '0;
          state_d      = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // The RAM read register is the output register. A read is issued whenever
  // that register is empty or being emptied this cycle, which keeps beats of
  // a committed frame back to back and holds data steady during a stall.
  assign out_hs = out_valid_q && cmac_tx_axis_tready;
  assign ram_re = (!out_valid_q || out_hs) && (rd_ptr_q != wr_commit_q);

  always_comb begin
    rd_ptr_d      = rd_ptr_q + PW'(ram_re);
    out_valid_d   = ram_re || (out_valid_q && !out_hs);
    frame_count_d = frame_count_q + PW'(commit_q) - PW'(out_hs && cmac_tx_axis_tlast);
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      state_q       <= WR_IDLE;
      wr_ptr_q      <= '0;
      wr_commit_q   <= '0;
      rd_ptr_q      <= '0;
      beat_cnt_q    <= '0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
      commit_q      <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      wr_commit_q   <= wr_commit_d;
      rd_ptr_q      <= rd_ptr_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
      commit_q      <= commit_d;
      out_valid_q   <= out_valid_d;
    end
  end

  sdp_ram #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (tx_axis_aclk),
    .we    (ram_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .re    (ram_re),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign {cmac_tx_axis_tlast, cmac_tx_axis_tkeep, cmac_tx_axis_tdata} = ram_rdata;
  assign cmac_tx_axis_tvalid = out_valid_q;
  assign frame_count         = frame_count_q;
  assign drop_count          = drop_count_q;

endmodule

// File: tb/tb_cmac_tx_frame_buffer.sv
// tb/tb_cmac_tx_frame_buffer.sv - self-checking bench for cmac_tx_frame_buffer
module tb_cmac_tx_frame_buffer;

  localparam int DW  = 512;
  localparam int KW  = 64;
  localparam int PW  = 7;
  localparam int MAXB = 24;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast, m_tready;
  logic [PW-1:0] frame_count;
  logic [31:0]   drop_count;

  typedef struct packed {
    logic          l;
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    int len;
    int exp_drop;
    int exp_wrptr;
  } vec_t;

  beat_t exp_q[$];
  int    n_cmp = 0, n_fail = 0;
  int    cyc = 0, out_cnt = 0, seq = 0;
  int    model_drops = 0, model_wr = 0;
  int    rdy_mode = 1;  // 0: low, 1: high, 2: random, 3: manual

  cmac_tx_frame_buffer dut (
    .tx_axis_aclk        (clk),
    .tx_axis_areset      (areset),
    .s_axis_tdata        (s_tdata),
    .s_axis_tkeep        (s_tkeep),
    .s_axis_tvalid       (s_tvalid),
    .s_axis_tlast        (s_tlast),
    .s_axis_tready       (s_tready),
    .cmac_tx_axis_tdata  (m_tdata),
    .cmac_tx_axis_tkeep  (m_tkeep),
    .cmac_tx_axis_tvalid (m_tvalid),
    .cmac_tx_axis_tlast  (m_tlast),
    .cmac_tx_axis_tready (m_tready),
    .frame_count         (frame_count),
    .drop_count          (drop_count)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_tready = 1'b0;
        1: m_tready = 1'b1;
        2: m_tready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // output scoreboard: order/content, no bubbles inside a frame, stable while stalled
  initial begin
    logic  in_frame = 1'b0;
    logic  stalled = 1'b0;
    beat_t held, cur, e;
    forever begin
      @(negedge clk);
      cur = '{l: m_tlast, k: m_tkeep, d: m_tdata};
      if (areset) begin
        in_frame = 1'b0;
        stalled  = 1'b0;
      end else begin
        if (stalled) begin
          n_cmp++;
          if (!m_tvalid || cur !== held) begin
            n_fail++;
            $display("FAIL hold_stable: got valid=%0b data_lo=%h expected valid=1 data_lo=%h",
                     m_tvalid, cur.d[63:0], held.d[63:0]);
          end
        end
        if (in_frame) check("no_bubble", 64'(m_tvalid), 64'd1);
        if (m_tvalid && m_tready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL out_beat: got unexpected beat data_lo=%h expected none", cur.d[63:0]);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL out_beat: got last=%0b keep=%h data=%h expected last=%0b keep=%h data=%h",
                       cur.l, cur.k, cur.d, e.l, e.k, e.d);
            end
          end
          out_cnt++;
          in_frame = !m_tlast;
        end
        stalled = m_tvalid && !m_tready;
        held    = cur;
      end
    end
  end

  // called and returns at posedge+1
  task automatic send_frame(input int len);
    beat_t fr[$];
    beat_t b;
    logic  acc;
    int    w;
    for (int i = 0; i < len; i++) begin
      for (int j = 0; j < DW / 32; j++) b.d[j*32 +: 32] = $urandom;
      b.d[31:0] = 32'(seq);
      seq++;
      b.l = (i == len - 1);
      b.k = b.l ? ({$urandom, $urandom} | 64'h1) : '1;
      fr.push_back(b);
    end
    if (len <= MAXB) begin
      foreach (fr[i]) exp_q.push_back(fr[i]);
      model_wr = (model_wr + len) % 128;
    end else begin
      model_drops++;
    end
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = fr[i].d;
      s_tkeep  = fr[i].k;
      s_tlast  = fr[i].l;
      w = 0;
      do begin
        @(negedge clk);
        acc = s_tready;
        @(posedge clk);
        #1;
        w++;
      end while (!acc && w < 2000);
      if (!acc) begin
        check("in_accept_timeout", 64'(acc), 64'd1);
        s_tvalid = 1'b0;
        return;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((exp_q.size() != 0 || m_tvalid) && w < 5000) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    exp_q.delete();
    model_drops = 0;
    model_wr    = 0;
    repeat (2) begin
      @(negedge clk);
      check("rst_s_tready", 64'(s_tready), 64'd0);
      @(posedge clk);
      #1;
    end
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    areset = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    int   base;
    int   t0;
    int   w;
    tbl[0] = '{len: 1,  exp_drop: 0, exp_wrptr: 1};
    tbl[1] = '{len: 3,  exp_drop: 0, exp_wrptr: 4};
    tbl[2] = '{len: 24, exp_drop: 0, exp_wrptr: 28};
    tbl[3] = '{len: 25, exp_drop: 1, exp_wrptr: 28};
    tbl[4] = '{len: 2,  exp_drop: 1, exp_wrptr: 30};
    tbl[5] = '{len: 26, exp_drop: 2, exp_wrptr: 30};
    tbl[6] = '{len: 30, exp_drop: 3, exp_wrptr: 30};
    tbl[7] = '{len: 1,  exp_drop: 3, exp_wrptr: 31};

    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    s_tkeep  = '0;
    do_reset();
    @(negedge clk);
    check("idle_s_tready", 64'(s_tready), 64'd1);
    @(posedge clk);
    #1;

    // single 3-beat frame: latency and frame_count 1 -> 0
    rdy_mode = 1;
    base = out_cnt;
    send_frame(3);
    @(negedge clk);
    check("lat_tvalid_c1", 64'(m_tvalid), 64'd0);
    check("lat_fc_c1", 64'(frame_count), 64'd0);
    @(negedge clk);
    check("lat_tvalid_c2", 64'(m_tvalid), 64'd1);
    check("lat_fc_c2", 64'(frame_count), 64'd1);
    @(posedge clk);
    #1;
    wait_drain();
    check("f3_beats", 64'(out_cnt - base), 64'd3);
    check("f3_fc_end", 64'(frame_count), 64'd0);

    // table of frame lengths including oversize frames
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].len);
      wait_drain();
      check($sformatf("tbl%0d_drop", i), 64'(drop_count), 64'(tbl[i].exp_drop));
      check($sformatf("tbl%0d_wrptr", i), 64'(dut.wr_ptr_q), 64'(tbl[i].exp_wrptr));
      check($sformatf("tbl%0d_fc", i), 64'(frame_count), 64'd0);
    end
    check("tbl_model_wrptr", 64'(dut.wr_ptr_q), 64'(model_wr));

    // backpressure with output stalled
    do_reset();
    rdy_mode = 0;
    base = out_cnt;
    send_frame(24);
    send_frame(24);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_fc", 64'(frame_count), 64'd2);
    @(posedge clk);
    #1;
    fork
      send_frame(24);
      begin
        repeat (20) begin
          @(negedge clk);
          check("bp_s_tready", 64'(s_tready), 64'd0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    wait_drain();
    check("bp_beats", 64'(out_cnt - base), 64'd72);
    check("bp_fc_end", 64'(frame_count), 64'd0);

    // random output ready with 1-beat frames
    rdy_mode = 2;
    t0 = cyc;
    while (cyc < t0 + 200) send_frame(1);
    rdy_mode = 1;
    wait_drain();
    check("rnd1_fc", 64'(frame_count), 64'd0);

    // random lengths, some oversize, random output ready
    rdy_mode = 2;
    repeat (30) send_frame(int'($urandom_range(1, 28)));
    rdy_mode = 1;
    wait_drain();
    check("rnd_drops", 64'(drop_count), 64'(model_drops));
    check("rnd_wrptr", 64'(dut.wr_ptr_q), 64'(model_wr));
    check("rnd_fc", 64'(frame_count), 64'd0);

    // reset while beat 2 of an output frame is presented
    do_reset();
    rdy_mode = 1;
    send_frame(25);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("mr_drop_pre", 64'(drop_count), 64'd1);
    rdy_mode = 3;
    m_tready = 1'b0;
    send_frame(3);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!m_tvalid && w < 10);
    check("mr_first_valid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    areset   = 1'b1;
    exp_q.delete();
    model_drops = 0;
    model_wr    = 0;
    @(negedge clk);
    check("mr_beat2_valid", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mr_tvalid", 64'(m_tvalid), 64'd0);
    check("mr_fc", 64'(frame_count), 64'd0);
    check("mr_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #1;
    areset   = 1'b0;
    rdy_mode = 1;
    base = out_cnt;
    send_frame(1);
    wait_drain();
    check("mr_after_beats", 64'(out_cnt - base), 64'd1);
    check("mr_after_fc", 64'(frame_count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
